// File: rtl/ariane_pkg.sv
// Shared core types: scoreboard entry, exception record and sizing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ariane_pkg;

  // Scoreboard depth and derived transaction-id width
  localparam int unsigned NR_SB_ENTRIES = 4;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  // Number of functional-unit write-back ports
  localparam int unsigned NR_WB_PORTS = 2;

  // Architectural register index width
  localparam int unsigned REG_ADDR_SIZE = 5;

  // Exception causes used by the load/store path
  localparam logic [63:0] INSTR_ACCESS_FAULT = 64'd1;
  localparam logic [63:0] ILLEGAL_INSTR      = 64'd2;
  localparam logic [63:0] LD_ACCESS_FAULT    = 64'd5;

  typedef enum logic [3:0] {
    FU_NONE,
    FU_LOAD,
    FU_STORE,
    FU_ALU,
    FU_CTRL_FLOW,
    FU_MULT,
    FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [7:0]               op;
    logic [REG_ADDR_SIZE-1:0] rs1;
    logic [REG_ADDR_SIZE-1:0] rs2;
    logic [REG_ADDR_SIZE-1:0] rd;
    logic [63:0]              result;
    logic                     valid;
    logic                     use_imm;
    exception                 ex;
  } scoreboard_entry;

endpackage

// File: rtl/scoreboard.sv
// In-order issue/commit buffer: circular store of decoded entries, stamped with their slot as trans_id.
// Latency: accepted entry visible to issue/lookup next cycle; write-back makes it committable next cycle.
// Backpressure: insert refused while full (registered count only); issue/commit acks ignored when not valid.
module scoreboard
  import ariane_pkg::*;
#(
  // Must be a power of two equal to 2**TRANS_ID_BITS so pointers wrap naturally
  parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES,
  parameter int unsigned NR_WB      = NR_WB_PORTS
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  output logic                                  full_o,
  // decode side
  input  scoreboard_entry                       decoded_instr_i,
  input  logic                                  decoded_instr_valid_i,
  output logic                                  decoded_instr_ack_o,
  // issue side
  output scoreboard_entry                       issue_instr_o,
  output logic                                  issue_instr_valid_o,
  input  logic                                  issue_ack_i,
  // operand queries
  input  logic [REG_ADDR_SIZE-1:0]              rs1_i,
  input  logic [REG_ADDR_SIZE-1:0]              rs2_i,
  output logic                                  rs1_busy_o,
  output logic                                  rs2_busy_o,
  output logic                                  rs1_fwd_valid_o,
  output logic                                  rs2_fwd_valid_o,
  output logic [63:0]                           rs1_o,
  output logic [63:0]                           rs2_o,
  // write-back ports
  input  logic [NR_WB-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB-1:0][63:0]                wb_data_i,
  input  exception [NR_WB-1:0]                  wb_ex_i,
  input  logic [NR_WB-1:0]                      wb_valid_i,
  // commit side
  output scoreboard_entry                       commit_instr_o,
  output logic                                  commit_valid_o,
  input  logic                                  commit_ack_i
);

  localparam int unsigned      PTR_W      = TRANS_ID_BITS;
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(NR_ENTRIES);

  // Result of an operand lookup
  typedef struct packed {
    logic        busy;
    logic        fwd_valid;
    logic [63:0] data;
  } lookup_t;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] issue_q, issue_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  // Disambiguates issue==tail on a full buffer: set once every occupied entry has been issued
  logic             issued_all_q, issued_all_d;

  scoreboard_entry  mem_q [NR_ENTRIES];
  scoreboard_entry  mem_d [NR_ENTRIES];

  logic [NR_ENTRIES-1:0] occupied;
  logic insert_fire, issue_fire, commit_fire;
  logic wb_conflict;
  lookup_t rs1_res, rs2_res;

  // Youngest occupied slot writing rs, searched from tail-1 backwards; x0 never matches
  function automatic lookup_t find_youngest(
    input logic [REG_ADDR_SIZE-1:0] rs,
    input scoreboard_entry          slots [NR_ENTRIES],
    input logic [NR_ENTRIES-1:0]    occ,
    input logic [PTR_W-1:0]         tail
  );
    lookup_t          res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int j = 1; j <= int'(NR_ENTRIES); j++) begin
      idx = tail - PTR_W'(j);
      if (!res.busy && (rs != '0) && occ[idx] && (slots[idx].rd == rs)) begin
        res.busy      = 1'b1;
        res.fwd_valid = slots[idx].valid;
        res.data      = slots[idx].result;
      end
    end
    return res;
  endfunction

  // A slot is occupied when its distance from head is below the live count
  always_comb begin
    occupied = '0;
    for (int i = 0; i < int'(NR_ENTRIES); i++) begin
      occupied[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q);
    end
  end

  // Status outputs come straight from registers so no ack feeds back into full/valid
  assign full_o              = (count_q == FULL_COUNT);
  assign issue_instr_valid_o = (issue_q != tail_q) ||
                               ((count_q == FULL_COUNT) && (issue_q == head_q) && !issued_all_q);
  assign commit_valid_o      = (count_q != '0) && mem_q[head_q].valid;
  assign issue_instr_o       = mem_q[issue_q];
  assign commit_instr_o      = mem_q[head_q];

  assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign insert_fire         = decoded_instr_ack_o;
  assign issue_fire          = issue_ack_i & issue_instr_valid_o & ~flush_i;
  assign commit_fire         = commit_ack_i & commit_valid_o & ~flush_i;

  // Operand busy/forward lookups for the issue stage
  always_comb begin
    rs1_res         = find_youngest(rs1_i, mem_q, occupied, tail_q);
    rs2_res         = find_youngest(rs2_i, mem_q, occupied, tail_q);
    rs1_busy_o      = rs1_res.busy;
    rs1_fwd_valid_o = rs1_res.fwd_valid;
    rs1_o           = rs1_res.data;
    rs2_busy_o      = rs2_res.busy;
    rs2_fwd_valid_o = rs2_res.fwd_valid;
    rs2_o           = rs2_res.data;
  end

  // Next-state: flush wins; otherwise write-back, commit, issue and insert are applied together
  always_comb begin
    head_d       = head_q;
    issue_d      = issue_q;
    tail_d       = tail_q;
    count_d      = count_q;
    issued_all_d = issued_all_q;
    mem_d        = mem_q;

    if (flush_i) begin
      head_d       = '0;
      issue_d      = '0;
      tail_d       = '0;
      count_d      = '0;
      issued_all_d = 1'b0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        mem_d[i].valid = 1'b0;
      end
    end else begin
      // Highest port first so the lowest-indexed port wins a same-slot collision.
      // Only registered occupancy counts, so a slot inserted this cycle ignores write-backs.
      for (int k = int'(NR_WB) - 1; k >= 0; k--) begin
        if (wb_valid_i[k] && occupied[wb_trans_id_i[k]]) begin
          mem_d[wb_trans_id_i[k]].result = wb_data_i[k];
          mem_d[wb_trans_id_i[k]].ex     = wb_ex_i[k];
          mem_d[wb_trans_id_i[k]].valid  = 1'b1;
        end
      end

      // Retire head; commit_fire used the registered valid bit, not this cycle's write-back
      if (commit_fire) begin
        mem_d[head_q].valid = 1'b0;
        head_d              = head_q + PTR_ONE;
      end

      if (issue_fire) begin
        issue_d = issue_q + PTR_ONE;
      end

      // Stamp slot index; decode-time exceptions are immediately committable
      if (insert_fire) begin
        mem_d[tail_q]          = decoded_instr_i;
        mem_d[tail_q].trans_id = tail_q;
        mem_d[tail_q].valid    = decoded_instr_i.ex.valid;
        tail_d                 = tail_q + PTR_ONE;
      end

      count_d = count_q + {{PTR_W{1'b0}}, insert_fire} - {{PTR_W{1'b0}}, commit_fire};

      // A fresh insert always leaves something unissued; issuing alone catches up when issue reaches tail
      if (insert_fire) begin
        issued_all_d = 1'b0;
      end else if (issue_fire) begin
        issued_all_d = ((issue_q + PTR_ONE) == tail_q);
      end
    end
  end

  // State registers; reset clears the whole store so entry outputs read zero
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q       <= '0;
      issue_q      <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      issued_all_q <= 1'b0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q       <= head_d;
      issue_q      <= issue_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      issued_all_q <= issued_all_d;
      mem_q        <= mem_d;
    end
  end

  // Two write-back ports targeting the same transaction in one cycle is a functional-unit bug
  always_comb begin
    wb_conflict = 1'b0;
    for (int a = 0; a < int'(NR_WB); a++) begin
      for (int b = a + 1; b < int'(NR_WB); b++) begin
        if (wb_valid_i[a] && wb_valid_i[b] && (wb_trans_id_i[a] == wb_trans_id_i[b])) begin
          wb_conflict = 1'b1;
        end
      end
    end
  end

  wb_unique_slot: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) !wb_conflict);

endmodule

// File: doc/scoreboard.md
# scoreboard

In-order issue/commit buffer between decode and the execute/commit stages. Holds up to `NR_SB_ENTRIES` `scoreboard_entry` records in a circular buffer and stamps each inserted entry with its slot index as `trans_id`. Records write-back results and exceptions from the functional units, and presents the oldest entry to commit. Also answers operand busy/forward queries for the issue logic.

## Interface
Parameters:
- `NR_ENTRIES`, default `NR_SB_ENTRIES` (4): slots; must be a power of two.
- `NR_WB`, default `NR_WB_PORTS` (2): number of write-back ports.

Ports:
- Clock and reset: one clock, `clk_i`; reset is synchronous and active-low, `rst_ni`.
- `flush_i`, in, 1: discard all entries.
- `full_o`, out, 1: all slots occupied.
- `decoded_instr_i`, in, `scoreboard_entry`: entry from decode.
- `decoded_instr_valid_i`, in, 1.
- `decoded_instr_ack_o`, out, 1: insertion accepted this cycle.
- `issue_instr_o`, out, `scoreboard_entry`: oldest not-yet-issued entry.
- `issue_instr_valid_o`, out, 1.
- `issue_ack_i`, in, 1: issue logic consumed `issue_instr_o`.
- `rs1_i`, `rs2_i`, in, 5: operand registers to query.
- `rs1_busy_o`, `rs2_busy_o`, out, 1: an occupied entry writes this register.
- `rs1_fwd_valid_o`, `rs2_fwd_valid_o`, out, 1: the youngest matching entry has a valid result.
- `rs1_o`, `rs2_o`, out, 64: forwarded result.
- `wb_trans_id_i`, in, `NR_WB`×`TRANS_ID_BITS`.
- `wb_data_i`, in, `NR_WB`×64.
- `wb_ex_i`, in, `NR_WB`×`exception`.
- `wb_valid_i`, in, `NR_WB`.
- `commit_instr_o`, out, `scoreboard_entry`: entry at head.
- `commit_valid_o`, out, 1: the head is occupied and its `valid` bit is set.
- `commit_ack_i`, in, 1: retire the head.

## Operation
- State:
  - `head` (commit), `issue`, and `tail` (insert) pointers, each `TRANS_ID_BITS` wide. They wrap modulo `NR_ENTRIES` naturally.
  - `count`, `TRANS_ID_BITS+1` wide.
  - Per-slot entry register.
- Insert:
  - `decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i`.
  - `full_o` depends only on registered `count`. There is no path from `commit_ack_i` to `full_o` or `decoded_instr_ack_o`.
  - The stored entry equals the input with `trans_id := tail` and `valid := 0`. Input `result` (the immediate) is kept.
  - If `decoded_instr_i.ex.valid` is set, the entry is stored with `valid := 1` so it can commit.
- Issue:
  - `issue_instr_valid_o` is high when the `issue` pointer is not equal to `tail`, or when `count==NR_ENTRIES` with `issue==head` and the head is not yet issued. Track this with one `issued_all` flag.
  - `issue_ack_i` while valid advances `issue`.
  - `issue_ack_i` while not valid is ignored.
- Write-back:
  - For each port `k` with `wb_valid_i[k]`: if slot `wb_trans_id_i[k]` is occupied, set `result := wb_data_i[k]`, `ex := wb_ex_i[k]`, `valid := 1`.
  - Write-backs to unoccupied slots are dropped.
  - If two ports hit the same slot, the lower port index wins; this is an illegal condition flagged by an assertion.
- Commit:
  - `commit_ack_i` while `commit_valid_o` frees the head, advances `head`, and decrements `count`.
  - `commit_ack_i` while not valid is ignored.
- Operand lookup:
  - Scan occupied slots with `rd==rs` and `rs!=0`.
  - Busy if any slot matches.
  - Forward from the youngest match, ordered from `tail-1` backward. `rs*_fwd_valid_o` is set only if that slot's `valid` is set.
  - `rs*_o` is 0 when there is no match.
- Simultaneous events:
  - Insert and commit in the same cycle: `count` is unchanged.
  - Write-back in the same cycle as insert into the same slot is impossible, because the slot is unoccupied until the next cycle; the write-back is dropped.
  - Commit and write-back to the head in the same cycle: commit sees the old (registered) `valid` bit.
- Flush:
  - Highest priority.
  - In the same cycle, all pointers, `count`, `issued_all` and all slot `valid` bits go to 0.
  - Insert, issue, write-back and commit are suppressed.
  - Outputs reflect the empty state next cycle.

## Timing
- Reset (`rst_ni==0` at a rising edge) has the same effect as flush.
- All registered outputs are 0 after reset: `full_o`, `issue_instr_valid_o`, `commit_valid_o`, `commit_instr_o`, `issue_instr_o`.
- Entry accepted at edge N: visible on `issue_instr_o` and to operand lookup at N+1.
- Write-back at edge N: `commit_valid_o` and `rs*_fwd_valid_o` are high from N+1.
- `commit_valid_o`, `issue_instr_valid_o` and `full_o` are derived from registers only.
- Lookup outputs are combinational from `rs*_i` and registered slots.
- Minimum insert→commit latency for a single-cycle FU: 2 cycles.

## Structure
- Use the existing shared package `ariane_pkg` for `NR_SB_ENTRIES`, `TRANS_ID_BITS`, `NR_WB_PORTS`, `scoreboard_entry` and `exception`. No new package types.
- Single module; no sub-module. The youngest-match search is a local function called for rs1 and rs2.

## Test plan
- Fill to full: insert 4 entries with `rd`=1..4 and `decoded_instr_valid_i` held high. Required: `trans_id` = 0,1,2,3; `full_o`=1 after the 4th edge; the 5th insert is not acked.
- Out-of-order write-back: write back tid2 (0xAA), then tid0 (0x55). Required: `commit_valid_o` only after tid0; commit order is tid0, tid1 (after its write-back), tid2 with `result`=0xAA.
- Forwarding: two entries both with `rd`=5, only the younger written with 0x1234, `rs1_i`=5. Required: busy=1, `fwd_valid`=1, `rs1_o`=0x1234. With `rs1_i`=0: busy=0.
- Full plus simultaneous commit: full buffer with `commit_ack_i` and insert both asserted. Required: insert not acked; `count`=3 next cycle; insert acked the following cycle with `trans_id`=0 (wrap).
- Flush mid-operation: 3 entries, 1 issued, write-back to tid1 in the flush cycle. Required: next cycle all valids are 0, `full_o`=0; the next insert gets tid0.
- Exception write-back: `wb_ex_i.valid`=1 with cause `LD_ACCESS_FAULT` on the head. Required: commit presents `ex.valid`=1, `ex.cause`=5.
